// File: rtl/axil_reg_slave.sv
// ---------------------------------------------------------------------------
// axil_reg_slave
//
// Parametrised AXI4-Lite slave register bank.  NUM_REGS registers of DATA_W
// bits are written and read over AXI4-Lite.  The whole bank is exposed flat
// on hw_out, with a one-cycle wr_pulse per register on every committed write.
// Registers flagged in RO_MASK are read-only: reads return the matching
// hw_in slice, writes are refused with SLVERR, and their hw_out slot reads 0.
//
// Configuration macro:
//   AXIL_REG_WSTRB_EN  defined   : byte lanes updated according to wstrb
//                      undefined : wstrb ignored, every accepted write
//                                  replaces the full word
//
// Ports:
//   s_axi_aclk, s_axi_areset          clock, async active-high reset
//   s_axi_aw* / s_axi_w* / s_axi_b*   write address, data, response channels
//   s_axi_ar* / s_axi_r*              read address and data channels
//   hw_out   [NUM_REGS*DATA_W]        register contents, reg i at [i*DATA_W +: DATA_W]
//   hw_in    [NUM_REGS*DATA_W]        source values for read-only registers
//   wr_pulse [NUM_REGS]               one-cycle pulse per committed write
//
// Handshake rule (all channels): a transfer happens on a rising edge where
// VALID and READY are both 1.  A source holds VALID and its payload stable
// until that edge; this slave holds bvalid/bresp and rvalid/rdata/rresp
// stable until their handshake.
// ---------------------------------------------------------------------------
module axil_reg_slave #(
    parameter int                  ADDR_W   = 5,
    parameter int                  DATA_W   = 32,
    parameter int                  NUM_REGS = 8,
    parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
    input  logic                         s_axi_aclk,
    input  logic                         s_axi_areset,
    input  logic [ADDR_W-1:0]            s_axi_awaddr,
    input  logic                         s_axi_awvalid,
    output logic                         s_axi_awready,
    input  logic [DATA_W-1:0]            s_axi_wdata,
    input  logic [DATA_W/8-1:0]          s_axi_wstrb,
    input  logic                         s_axi_wvalid,
    output logic                         s_axi_wready,
    output logic [1:0]                   s_axi_bresp,
    output logic                         s_axi_bvalid,
    input  logic                         s_axi_bready,
    input  logic [ADDR_W-1:0]            s_axi_araddr,
    input  logic                         s_axi_arvalid,
    output logic                         s_axi_arready,
    output logic [DATA_W-1:0]            s_axi_rdata,
    output logic [1:0]                   s_axi_rresp,
    output logic                         s_axi_rvalid,
    input  logic                         s_axi_rready,
    output logic [NUM_REGS*DATA_W-1:0]   hw_out,
    input  logic [NUM_REGS*DATA_W-1:0]   hw_in,
    output logic [NUM_REGS-1:0]          wr_pulse
);

    localparam int STRB_W = DATA_W / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int IDX_W  = ADDR_W - LSB;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic { W_COLLECT, W_RESP } w_state_t;
    typedef enum logic { R_IDLE,    R_DATA } r_state_t;

    // Register storage
    logic [DATA_W-1:0]   r_regs [NUM_REGS];

    // Write channel state
    w_state_t            r_wstate;
    logic                r_awready;
    logic                r_wready;
    logic                r_bvalid;
    logic [1:0]          r_bresp;
    logic [IDX_W-1:0]    r_awidx;
    logic [DATA_W-1:0]   r_wdata;
    logic [NUM_REGS-1:0] r_wr_pulse;
`ifdef AXIL_REG_WSTRB_EN
    logic [STRB_W-1:0]   r_wstrb;
    logic [STRB_W-1:0]   w_wstrb;
`endif

    // Read channel state
    r_state_t            r_rstate;
    logic                r_arready;
    logic                r_rvalid;
    logic [DATA_W-1:0]   r_rdata;
    logic [1:0]          r_rresp;

    // Write-side combinational signals
    logic                w_aw_hs;
    logic                w_w_hs;
    logic                w_aw_have;
    logic                w_w_have;
    logic                w_commit;
    logic [IDX_W-1:0]    w_widx;
    logic [DATA_W-1:0]   w_wdata;
    logic [NUM_REGS-1:0] w_wsel;
    logic                w_werr;

    // Read-side combinational signals
    logic [IDX_W-1:0]    w_ridx;
    logic                w_rhit;
    logic [DATA_W-1:0]   w_rword;

    logic [NUM_REGS*DATA_W-1:0] w_hw_out;

    // -----------------------------------------------------------------------
    // Write path.  awready/wready double as "not yet latched" flags while in
    // W_COLLECT, so a beat counts as available if it is latched already or
    // is handshaking this cycle.  The commit happens on the edge where the
    // second of the two beats arrives, using the live bus value for whichever
    // beat is arriving right now.
    // -----------------------------------------------------------------------
    assign w_aw_hs   = r_awready & s_axi_awvalid;
    assign w_w_hs    = r_wready  & s_axi_wvalid;
    assign w_aw_have = w_aw_hs | ~r_awready;
    assign w_w_have  = w_w_hs  | ~r_wready;
    assign w_commit  = (r_wstate == W_COLLECT) & w_aw_have & w_w_have;

    assign w_widx  = r_awready ? s_axi_awaddr[ADDR_W-1:LSB] : r_awidx;
    assign w_wdata = r_wready  ? s_axi_wdata : r_wdata;
`ifdef AXIL_REG_WSTRB_EN
    assign w_wstrb = r_wready  ? s_axi_wstrb : r_wstrb;
`endif

    // One-hot select of the writable target; all-zero means SLVERR
    // (out-of-range index or read-only register).
    always_comb begin
        w_wsel = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_wsel[i] = (w_widx == IDX_W'(i)) && !RO_MASK[i];
        end
    end
    assign w_werr = ~|w_wsel;

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            r_wstate   <= W_COLLECT;
            r_awready  <= 1'b1;
            r_wready   <= 1'b1;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
            r_awidx    <= '0;
            r_wdata    <= '0;
            r_wr_pulse <= '0;
`ifdef AXIL_REG_WSTRB_EN
            r_wstrb    <= '0;
`endif
        end else begin
            r_wr_pulse <= '0;
            case (r_wstate)
                W_COLLECT: begin
                    if (w_aw_hs) begin
                        r_awidx   <= s_axi_awaddr[ADDR_W-1:LSB];
                        r_awready <= 1'b0;
                    end
                    if (w_w_hs) begin
                        r_wdata  <= s_axi_wdata;
`ifdef AXIL_REG_WSTRB_EN
                        r_wstrb  <= s_axi_wstrb;
`endif
                        r_wready <= 1'b0;
                    end
                    if (w_commit) begin
                        r_awready  <= 1'b0;
                        r_wready   <= 1'b0;
                        r_bvalid   <= 1'b1;
                        r_bresp    <= w_werr ? RESP_SLVERR : RESP_OKAY;
                        r_wr_pulse <= w_wsel;
                        r_wstate   <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                        r_wstate  <= W_COLLECT;
                    end
                end
                default: r_wstate <= W_COLLECT;
            endcase
        end
    end

    // Register bank update, only on the commit edge.
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_wsel[i]) begin
`ifdef AXIL_REG_WSTRB_EN
                    for (int k = 0; k < STRB_W; k++) begin
                        if (w_wstrb[k]) begin
                            r_regs[i][8*k +: 8] <= w_wdata[8*k +: 8];
                        end
                    end
`else
                    r_regs[i] <= w_wdata;
`endif
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Read path.  The word is sampled on the AR handshake edge, so a write
    // committing on that same edge is not yet visible to this read.
    // -----------------------------------------------------------------------
    assign w_ridx = s_axi_araddr[ADDR_W-1:LSB];

    always_comb begin
        w_rhit  = 1'b0;
        w_rword = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_ridx == IDX_W'(i)) begin
                w_rhit  = 1'b1;
                w_rword = RO_MASK[i] ? hw_in[i*DATA_W +: DATA_W] : r_regs[i];
            end
        end
    end

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b1;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (s_axi_arvalid) begin
                        r_rdata   <= w_rword;
                        r_rresp   <= w_rhit ? RESP_OKAY : RESP_SLVERR;
                        r_rvalid  <= 1'b1;
                        r_arready <= 1'b0;
                        r_rstate  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (s_axi_rready) begin
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                        r_rstate  <= R_IDLE;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    // Hardware-side view; read-only slots are forced to zero.
    always_comb begin
        w_hw_out = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_hw_out[i*DATA_W +: DATA_W] = RO_MASK[i] ? '0 : r_regs[i];
        end
    end

    // Byte-offset address bits and the hw_in slices of writable registers
    // carry no information for this block.
`ifdef AXIL_REG_WSTRB_EN
    logic w_unused;
    assign w_unused = ^{hw_in, s_axi_awaddr[LSB-1:0], s_axi_araddr[LSB-1:0]};
`else
    logic w_unused;
    assign w_unused = ^{hw_in, s_axi_awaddr[LSB-1:0], s_axi_araddr[LSB-1:0], s_axi_wstrb};
`endif

    assign s_axi_awready = r_awready;
    assign s_axi_wready  = r_wready;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_arready = r_arready;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = r_rresp;
    assign hw_out        = w_hw_out;
    assign wr_pulse      = r_wr_pulse;

endmodule

// File: tb/tb_axil_reg_slave.sv
// ---------------------------------------------------------------------------
// tb_axil_reg_slave
//
// Bench for axil_reg_slave configured with 6 registers, 5-bit addresses,
// 32-bit data and register 2 read-only.  Expected responses are pushed into
// queues when a transaction is issued; monitors pop and compare whenever the
// DUT presents a response.  The reference model is a plain array of words
// updated by byte-lane rules.
// ---------------------------------------------------------------------------
module tb_axil_reg_slave;

    localparam int             ADDR_W = 5;
    localparam int             DATA_W = 32;
    localparam int             NR     = 6;
    localparam logic [NR-1:0]  RO     = 6'b000100;
    localparam int             HW_W   = NR * DATA_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [ADDR_W-1:0]   awaddr = '0;
    logic                awvalid = 1'b0;
    logic                awready;
    logic [DATA_W-1:0]   wdata = '0;
    logic [DATA_W/8-1:0] wstrb = '0;
    logic                wvalid = 1'b0;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready = 1'b0;
    logic [ADDR_W-1:0]   araddr = '0;
    logic                arvalid = 1'b0;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready = 1'b0;
    logic [HW_W-1:0]     hw_out;
    logic [HW_W-1:0]     hw_in = '0;
    logic [NR-1:0]       wr_pulse;

    axil_reg_slave #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .NUM_REGS (NR),
        .RO_MASK  (RO)
    ) dut (
        .s_axi_aclk    (clk),
        .s_axi_areset  (rst),
        .s_axi_awaddr  (awaddr),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_bresp   (bresp),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .s_axi_araddr  (araddr),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready),
        .hw_out        (hw_out),
        .hw_in         (hw_in),
        .wr_pulse      (wr_pulse)
    );

    // ---------------- scoreboard state ----------------
    int                 n_vec = 0;
    int                 n_err = 0;
    logic [NR-1:0]      ro_v = RO;
    logic [DATA_W-1:0]  model [NR];
    logic [1:0]         exp_b_q [$];
    logic [DATA_W+1:0]  exp_r_q [$];
    logic [NR-1:0]      exp_p_q [$];
    logic [1:0]         cur_bresp;
    logic [NR-1:0]      cur_pulse;
    logic [DATA_W+1:0]  cur_r;
    logic               aw_hold = 1'b0;
    logic               w_hold  = 1'b0;

    task automatic chk(input string name, input logic [HW_W-1:0] act, input logic [HW_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: event occurred, none expected", name);
    endtask

    // ---------------- reference model ----------------
    function automatic int addr_idx(input logic [ADDR_W-1:0] a);
        return int'(a >> 2);
    endfunction

    function automatic logic [HW_W-1:0] exp_hw();
        logic [HW_W-1:0] v;
        v = '0;
        for (int i = 0; i < NR; i++) begin
            v[i*DATA_W +: DATA_W] = ro_v[i] ? '0 : model[i];
        end
        return v;
    endfunction

    task automatic expect_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                                input logic [3:0] s);
        int idx;
        idx = addr_idx(a);
        if (idx >= NR || ro_v[idx]) begin
            cur_bresp = 2'b10;
            cur_pulse = '0;
        end else begin
`ifdef AXIL_REG_WSTRB_EN
            for (int k = 0; k < 4; k++) begin
                if (s[k]) model[idx][8*k +: 8] = d[8*k +: 8];
            end
`else
            model[idx] = d;
`endif
            cur_bresp = 2'b00;
            cur_pulse = '0;
            cur_pulse[idx] = 1'b1;
            exp_p_q.push_back(cur_pulse);
        end
        exp_b_q.push_back(cur_bresp);
    endtask

    task automatic expect_read(input logic [ADDR_W-1:0] a);
        int idx;
        idx = addr_idx(a);
        if (idx >= NR)        cur_r = {2'b10, 32'h0};
        else if (ro_v[idx])   cur_r = {2'b00, hw_in[idx*DATA_W +: DATA_W]};
        else                  cur_r = {2'b00, model[idx]};
        exp_r_q.push_back(cur_r);
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                               input logic [3:0] s, input int aw_dly, input int w_dly);
        fork
            begin
                bit ok_a;
                ok_a = 1'b0;
                repeat (aw_dly) @(posedge clk);
                @(posedge clk); #1;
                awaddr = a; awvalid = 1'b1;
                for (int t = 0; t < 50 && !ok_a; t++) begin
                    @(negedge clk);
                    ok_a = awready;
                end
                if (ok_a) begin
                    @(posedge clk); #1;
                end else begin
                    fail_now("awready_timeout");
                end
                awvalid = 1'b0;
                aw_hold = ok_a;
            end
            begin
                bit ok_w;
                ok_w = 1'b0;
                repeat (w_dly) @(posedge clk);
                @(posedge clk); #1;
                wdata = d; wstrb = s; wvalid = 1'b1;
                for (int t = 0; t < 50 && !ok_w; t++) begin
                    @(negedge clk);
                    ok_w = wready;
                end
                if (ok_w) begin
                    @(posedge clk); #1;
                end else begin
                    fail_now("wready_timeout");
                end
                wvalid = 1'b0;
                w_hold = ok_w;
            end
        join
        // Commit is on the edge of the later handshake: response and pulse
        // must be visible in the very next cycle.
        @(negedge clk);
        chk("bvalid_after_commit", bvalid, 1'b1);
        chk("wr_pulse_timing", wr_pulse, cur_pulse);
    endtask

    task automatic finish_b(input int b_dly);
        repeat (b_dly) begin
            @(negedge clk);
            chk("bvalid_hold", bvalid, 1'b1);
            chk("bresp_hold", bresp, cur_bresp);
        end
        @(posedge clk); #1 bready = 1'b1;
        @(posedge clk); #1 bready = 1'b0;
        aw_hold = 1'b0;
        w_hold  = 1'b0;
        @(negedge clk);
        chk("bvalid_clear", bvalid, 1'b0);
        chk("awready_back", awready, 1'b1);
        chk("wready_back", wready, 1'b1);
        chk("hw_out", hw_out, exp_hw());
    endtask

    task automatic drive_read(input logic [ADDR_W-1:0] a, input int ar_dly, input int r_dly);
        bit ok_r;
        ok_r = 1'b0;
        repeat (ar_dly) @(posedge clk);
        @(posedge clk); #1;
        araddr = a; arvalid = 1'b1;
        for (int t = 0; t < 50 && !ok_r; t++) begin
            @(negedge clk);
            ok_r = arready;
        end
        if (ok_r) begin
            @(posedge clk); #1;
        end else begin
            fail_now("arready_timeout");
        end
        arvalid = 1'b0;
        @(negedge clk);
        chk("rvalid_after_ar", rvalid, 1'b1);
        repeat (r_dly) begin
            @(negedge clk);
            chk("rdata_hold", {rresp, rdata}, cur_r);
            chk("arready_low", arready, 1'b0);
        end
        @(posedge clk); #1 rready = 1'b1;
        @(posedge clk); #1 rready = 1'b0;
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                            input logic [3:0] s, input int aw_dly, input int w_dly, input int b_dly);
        expect_write(a, d, s);
        drive_write(a, d, s, aw_dly, w_dly);
        finish_b(b_dly);
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a, input int ar_dly, input int r_dly);
        expect_read(a);
        drive_read(a, ar_dly, r_dly);
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (!rst && bvalid && bready) begin
            if (exp_b_q.size() == 0) fail_now("bresp_unexpected");
            else chk("bresp", bresp, exp_b_q.pop_front());
        end
    end

    always @(negedge clk) begin
        if (!rst && rvalid && rready) begin
            if (exp_r_q.size() == 0) fail_now("rdata_unexpected");
            else chk("rresp_rdata", {rresp, rdata}, exp_r_q.pop_front());
        end
    end

    always @(negedge clk) begin
        if (!rst && wr_pulse != '0) begin
            if (exp_p_q.size() == 0) fail_now("wr_pulse_unexpected");
            else chk("wr_pulse", wr_pulse, exp_p_q.pop_front());
        end
    end

    always @(negedge clk) begin
        if (!rst && aw_hold) chk("awready_low_while_held", awready, 1'b0);
        if (!rst && w_hold)  chk("wready_low_while_held", wready, 1'b0);
    end

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < NR; i++) model[i] = '0;
        for (int i = 0; i < NR; i++) hw_in[i*DATA_W +: DATA_W] = $urandom;
        hw_in[2*DATA_W +: DATA_W] = 32'hCAFEF00D;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_awready", awready, 1'b1);
        chk("rst_wready", wready, 1'b1);
        chk("rst_arready", arready, 1'b1);
        chk("rst_bvalid", bvalid, 1'b0);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_bresp", bresp, 2'b00);
        chk("rst_rresp_rdata", {rresp, rdata}, '0);
        chk("rst_wr_pulse", wr_pulse, '0);
        chk("rst_hw_out", hw_out, '0);

        // Basic write/read, AW and W together
        do_write(5'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        do_read(5'h04, 0, 0);
        // W three cycles ahead of AW, then AW ahead of W
        do_write(5'h0C, 32'h12345678, 4'hF, 3, 0, 1);
        do_read(5'h0C, 0, 2);
        do_write(5'h14, 32'hA5A55A5A, 4'hF, 0, 2, 0);
        // Partial strobe and empty strobe
        do_write(5'h04, 32'h000000AA, 4'h1, 0, 0, 0);
        do_read(5'h04, 1, 0);
        do_write(5'h10, 32'h0BADCAFE, 4'h0, 1, 1, 0);
        do_read(5'h10, 0, 0);
        // Read-only register
        do_write(5'h08, 32'h11111111, 4'hF, 0, 0, 0);
        do_read(5'h08, 0, 0);
        // Out of range, unaligned addresses
        do_read(5'h18, 0, 1);
        do_write(5'h1C, 32'h22222222, 4'hF, 0, 0, 0);
        do_read(5'h1F, 0, 0);
        do_write(5'h07, 32'h33333333, 4'hC, 0, 1, 0);

        // AR handshake on the same edge as the write commit sees the old value
        expect_read(5'h0C);
        expect_write(5'h0C, 32'h87654321, 4'hF);
        fork
            drive_read(5'h0C, 0, 0);
            begin
                drive_write(5'h0C, 32'h87654321, 4'hF, 0, 0);
                finish_b(0);
            end
        join
        do_read(5'h0C, 0, 0);

        // Randomised traffic
        for (int n = 0; n < 60; n++) begin
            logic [ADDR_W-1:0] a;
            a = ADDR_W'($urandom_range(0, 31));
            if ($urandom_range(0, 9) == 0) hw_in[2*DATA_W +: DATA_W] = $urandom;
            if ($urandom_range(0, 1) == 0)
                do_read(a, $urandom_range(0, 2), $urandom_range(0, 2));
            else
                do_write(a, $urandom, 4'($urandom_range(0, 15)),
                         $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
        end

        // Hold the write response, then reset in the middle of the hold
        expect_write(5'h14, 32'h5A5A0001, 4'hF);
        drive_write(5'h14, 32'h5A5A0001, 4'hF, 0, 0);
        repeat (5) begin
            @(negedge clk);
            chk("bvalid_hold5", bvalid, 1'b1);
            chk("bresp_hold5", bresp, cur_bresp);
        end
        #2 rst = 1'b1;
        #1;
        chk("async_rst_bvalid", bvalid, 1'b0);
        chk("async_rst_awready", awready, 1'b1);
        chk("async_rst_wready", wready, 1'b1);
        chk("async_rst_hw_out", hw_out, '0);
        aw_hold = 1'b0;
        w_hold  = 1'b0;
        exp_b_q.delete();
        exp_p_q.delete();
        for (int i = 0; i < NR; i++) model[i] = '0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_awready", awready, 1'b1);
        do_read(5'h04, 0, 0);
        do_write(5'h00, 32'hFEEDFACE, 4'hF, 0, 0, 0);
        do_read(5'h00, 0, 0);

        repeat (3) @(negedge clk);
        chk("b_queue_drained", exp_b_q.size(), 0);
        chk("r_queue_drained", exp_r_q.size(), 0);
        chk("pulse_queue_drained", exp_p_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/axil_reg_slave.md
Name: axil_reg_slave

Overview:
- Parametrised AXI4-Lite slave register bank for the interrupt test environment.
- Generalises the fixed 5-bit-address, 32-bit-data AXI4-Lite port to configurable address width, data width and register count.
- Accepts AW and W in any order, supports per-register read-only masking and reports SLVERR.
- Exposes the register contents and per-register write strobes to the hardware side.

Parameters:
ADDR_W, 5, AXI address width in bits; must satisfy 2^ADDR_W >= NUM_REGS*DATA_W/8
DATA_W, 32, data width in bits; 32 or 64 only
NUM_REGS, 8, number of DATA_W-wide registers
RO_MASK, 0, NUM_REGS-bit mask; bit i=1 makes register i read-only, with its value taken from hw_in

Ports:
s_axi_aclk  in  1  single clock
s_axi_areset  in  1  asynchronous active-high reset
s_axi_awaddr  in  ADDR_W  write address
s_axi_awvalid  in  1  write address valid
s_axi_awready  out  1  write address ready
s_axi_wdata  in  DATA_W  write data
s_axi_wstrb  in  DATA_W/8  byte strobes
s_axi_wvalid  in  1  write data valid
s_axi_wready  out  1  write data ready
s_axi_bresp  out  2  write response (00 OKAY, 10 SLVERR)
s_axi_bvalid  out  1  write response valid
s_axi_bready  in  1  write response ready
s_axi_araddr  in  ADDR_W  read address
s_axi_arvalid  in  1  read address valid
s_axi_arready  out  1  read address ready
s_axi_rdata  out  DATA_W  read data
s_axi_rresp  out  2  read response
s_axi_rvalid  out  1  read data valid
s_axi_rready  in  1  read data ready
hw_out  out  NUM_REGS*DATA_W  flat register contents; register i at [i*DATA_W +: DATA_W]
hw_in  in  NUM_REGS*DATA_W  values for read-only registers
wr_pulse  out  NUM_REGS  one-cycle pulse on each committed write to register i

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - All registers 0; awready, wready, arready = 1.
  - bvalid, rvalid, wr_pulse = 0; bresp, rresp, rdata = 0.
  - Any in-flight transaction is dropped.
- Address decode:
  - idx = addr[ADDR_W-1 : log2(DATA_W/8)]; low byte-offset bits are ignored.
  - idx >= NUM_REGS is out of range.
- Write FSM, states W_COLLECT and W_RESP:
  - W_COLLECT: awready=1 until an AW is latched; wready=1 until a W is latched. AW and W are captured independently, same cycle or any order.
  - The cycle in which the second of the two handshakes completes is cycle N.
  - At edge N+1: commit the write, set bvalid=1, enter W_RESP.
  - W_RESP: awready=0, wready=0. bvalid holds with stable bresp until bvalid&&bready, then return to W_COLLECT with awready=wready=1 on the next cycle.
  - Commit rule: for a writable, in-range idx, each byte lane k with wstrb[k]=1 is updated; bresp=OKAY; wr_pulse[idx]=1 for exactly cycle N+1.
  - Out-of-range idx or RO_MASK[idx]=1: no register change, no pulse, bresp=SLVERR.
  - An all-zero wstrb is a legal OKAY write with no data change; wr_pulse still fires.
- Read FSM, states R_IDLE and R_DATA:
  - R_IDLE: arready=1. On arvalid&&arready at edge E: rdata is sampled and rvalid=1 after E, enter R_DATA with arready=0.
  - Data source is hw_in slice if RO_MASK[idx]=1, else the register. Out of range returns rdata=0, rresp=SLVERR.
  - rdata and rresp hold stable until rvalid&&rready, then return to R_IDLE.
- Simultaneous read and write to the same register:
  - The read samples the pre-commit value when its AR handshake edge equals the write commit edge.
  - A read handshaking after the commit edge returns the new value.
- Read and write channels are fully independent; neither blocks the other.
- hw_out reflects register state; RO register slots in hw_out read 0.

Optional Feature:
- Macro AXIL_REG_WSTRB_EN.
- Defined: byte-lane writes per wstrb, as above.
- Undefined: wstrb is ignored and every accepted write updates the full DATA_W word; the all-zero-strobe case becomes a full-word write.

Test Plan:
- Defaults, reset then write awaddr=0x04, wdata=0xDEADBEEF, wstrb=0xF with AW and W in the same cycle -> bvalid one cycle later, bresp=00; wr_pulse[1] high exactly 1 cycle; hw_out[63:32]=0xDEADBEEF; read 0x04 returns 0xDEADBEEF, rresp=00.
- W presented 3 cycles before AW (addr 0x08, data 0x12345678) -> wready drops after the W handshake; the write commits only after AW; register 2 = 0x12345678.
- With AXIL_REG_WSTRB_EN, register 1 = 0xDEADBEEF, write 0x000000AA with wstrb=0x1 -> register 1 = 0xDEADBEAA. Without the macro -> 0x000000AA.
- RO_MASK=8'h04, hw_in slot 2=0xCAFEF00D: write 0x08 -> bresp=10, no wr_pulse; read 0x08 -> 0xCAFEF00D, rresp=00.
- NUM_REGS=6, ADDR_W=5: read 0x18 -> rdata=0, rresp=10; write 0x1C -> bresp=10, no register changes.
- Hold bready=0 for 5 cycles -> bvalid and bresp stable, awready=wready=0. Assert reset mid-hold -> bvalid=0 immediately, registers 0, awready=1 after reset release.
